if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 The parameter list SHALL be: DEPTH, default 4, number of instruction FIFO entries (power of two, minimum 2).
REQ-002 The ports SHALL be:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  64  byte address of the requested word.
- imem_ack  in  1  memory returns imem_data this cycle.
- imem_data  in  32  instruction word, valid when imem_ack=1.
- Brtaken  in  1  redirect/flush strobe from the decode stage.
- branch_target  in  64  redirect PC, sampled when Brtaken=1.
- instru  out  32  instruction at FIFO head.
- instru_pc  out  64  PC of instru.
- instru_valid  out  1  FIFO head valid.
- instru_ready  in  1  consumer accepts head this cycle.

Function
REQ-003 The block SHALL have FSM states IDLE (no request), REQ (request outstanding) and DROP (request outstanding, result to be discarded).
REQ-004 The block SHALL allow at most one memory request outstanding.
REQ-005 imem_req and imem_addr SHALL be registered, and SHALL remain stable from assertion until the edge where imem_ack=1.
REQ-006 IDLE->REQ SHALL occur at a clk edge when count<DEPTH and Brtaken=0; imem_req=1 and imem_addr=fetch PC take effect after that edge.
REQ-007 REQ with imem_ack=1 and Brtaken=0 SHALL push {imem_data, imem_addr} into the FIFO, advance fetch PC by 4 (64-bit wrap), deassert imem_req and return to IDLE.
REQ-008 Back-to-back issue SHALL NOT occur: at least one IDLE cycle separates successive requests.
REQ-009 instru_valid SHALL equal (count!=0), and instru/instru_pc SHALL present the oldest entry.
REQ-010 A pop SHALL occur when instru_valid=1 and instru_ready=1.
REQ-011 A simultaneous push and pop SHALL leave count unchanged.
REQ-012 Latency: an ack at edge N SHALL make the word visible on instru after edge N (if the FIFO was empty).
REQ-013 When Brtaken=1 at an edge, the block SHALL:
- empty the FIFO (count=0);
- load fetch PC with {branch_target[63:2],2'b00};
- ignore any pop in that cycle.
REQ-014 Brtaken in state IDLE SHALL go to IDLE, with the new request issued at the next edge per REQ-006.
REQ-015 Brtaken in state REQ with imem_ack=0 SHALL go to DROP, keeping imem_req high and imem_addr unchanged until ack.
REQ-016 Brtaken in state REQ with imem_ack=1 SHALL discard the data, deassert imem_req and go to IDLE.
REQ-017 DROP with imem_ack=1 SHALL discard the data (no push, fetch PC unchanged) and go to IDLE.
REQ-018 Brtaken in state DROP SHALL update fetch PC only.
REQ-019 When the FIFO is full (count=DEPTH), no request SHALL issue; issue SHALL resume at the edge after count drops below DEPTH.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 count SHALL be $clog2(DEPTH)+1 bits wide.

Reset
REQ-022 While reset=0, asynchronously:
- state=IDLE, fetch PC=0, count=0, pointers=0;
- imem_req=0, imem_addr=0, instru_valid=0;
- instru and instru_pc SHALL be driven to 0.
REQ-023 Reset assertion mid-request SHALL abandon the request, and a late imem_ack after reset release SHALL be ignored (state IDLE).
REQ-024 The first imem_req SHALL assert after the first clk edge following reset=1, with imem_addr=0.

Verification
REQ-025 Reset release, ack every request one cycle after req, instru_ready=1 -> instru_pc sequence 0,4,8,12, with instru matching memory words.
REQ-026 instru_ready=0, acks immediate, DEPTH=4 -> exactly 4 pushes (PCs 0..12), imem_req stays 0 while full; one pop -> next req addr=16.
REQ-027 Brtaken=1 with branch_target=0x103 while FIFO holds 3 entries -> instru_valid=0 next cycle, next imem_addr=0x100.
REQ-028 Brtaken while REQ outstanding at addr 0x8, ack delayed 3 cycles, target 0x40 -> the 0x8 data is never delivered, next req addr=0x40.
REQ-029 Brtaken and imem_ack in the same cycle -> ack data dropped, count=0, next req addr=target.
REQ-030 Simultaneous push and pop at count=2 -> count stays 2 and order is preserved; reset=0 mid-REQ -> all outputs 0 immediately.

Source files
------------

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: issues one instruction-memory read at a time,
// queues returned words with their PCs in a small FIFO, and flushes or
// redirects on a taken branch from decode.
module if_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        Brtaken,
  input  logic [63:0] branch_target,
  output logic [31:0] instru,
  output logic [63:0] instru_pc,
  output logic        instru_valid,
  input  logic        instru_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t       state_reg, state_next;
  logic         imem_req_reg, imem_req_next;
  logic [63:0]  imem_addr_reg, imem_addr_next;
  logic [63:0]  fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]  count_reg;
  logic         push, pop;
  logic [63:0]  target_aligned;

  logic [31:0]  data_mem [DEPTH];
  logic [63:0]  pc_mem   [DEPTH];

  // Redirect target is always word aligned; the low two bits are ignored.
  assign target_aligned = branch_target & ~64'd3;

  assign instru_valid = (count_reg != '0);
  assign instru       = instru_valid ? data_mem[rd_ptr_reg] : '0;
  assign instru_pc    = instru_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign imem_req     = imem_req_reg;
  assign imem_addr    = imem_addr_reg;

  // A redirect takes priority over any consumer pop in the same cycle.
  assign pop = instru_valid && instru_ready && !Brtaken;

  // Next-state logic: one request in flight, DROP swallows a stale response.
  always_comb begin
    state_next     = state_reg;
    imem_req_next  = imem_req_reg;
    imem_addr_next = imem_addr_reg;
    fetch_pc_next  = fetch_pc_reg;
    push           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Brtaken) begin
          fetch_pc_next = target_aligned;
        end else if (count_reg < DEPTH_C) begin
          state_next     = REQ;
          imem_req_next  = 1'b1;
          imem_addr_next = fetch_pc_reg;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_next    = IDLE;
          imem_req_next = 1'b0;
          if (Brtaken) begin
            fetch_pc_next = target_aligned;
          end else begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + 64'd4;
          end
        end else if (Brtaken) begin
          state_next    = DROP;
          fetch_pc_next = target_aligned;
        end
      end
      DROP: begin
        if (Brtaken) fetch_pc_next = target_aligned;
        if (imem_ack) begin
          state_next    = IDLE;
          imem_req_next = 1'b0;
        end
      end
      default: begin
        state_next    = IDLE;
        imem_req_next = 1'b0;
      end
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      imem_req_reg  <= 1'b0;
      imem_addr_reg <= '0;
      fetch_pc_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      imem_req_reg  <= imem_req_next;
      imem_addr_reg <= imem_addr_next;
      fetch_pc_reg  <= fetch_pc_next;
    end
  end

  // FIFO occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (Brtaken) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= imem_data;
      pc_mem[wr_ptr_reg]   <= imem_addr_reg;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: drives memory responses and redirects,
// checks request addresses, FIFO head contents and reset behaviour.
module tb_if_prefetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        Brtaken;
  logic [63:0] branch_target;
  logic [31:0] instru;
  logic [63:0] instru_pc;
  logic        instru_valid;
  logic        instru_ready;

  int nvec = 0;
  int nerr = 0;
  bit auto_ack = 0;
  logic [63:0] seen_pc[$];
  logic [31:0] seen_data[$];

  if_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .Brtaken(Brtaken), .branch_target(branch_target),
    .instru(instru), .instru_pc(instru_pc),
    .instru_valid(instru_valid), .instru_ready(instru_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[31:0] * 32'd3) + 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // One clock: log the head that will pop, cross the edge, then model memory.
  task automatic step();
    if (instru_valid && instru_ready && !Brtaken) begin
      seen_pc.push_back(instru_pc);
      seen_data.push_back(instru);
    end
    @(posedge clk);
    #1;
    if (auto_ack) begin
      imem_ack  = imem_req;
      imem_data = imem_req ? word(imem_addr) : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 0; imem_ack = 0; imem_data = 0; Brtaken = 0; branch_target = 0;
    instru_ready = 0; auto_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    reset = 0; imem_ack = 0; imem_data = 0; Brtaken = 0;
    branch_target = 0; instru_ready = 0;

    // Reset state
    do_reset();
    reset = 0;
    #2;
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_valid", {63'd0, instru_valid}, 64'd0);
    check("rst_instru", {32'd0, instru}, 64'd0);
    check("rst_pc", instru_pc, 64'd0);

    // Streaming: ack one cycle after each request, consumer always ready
    do_reset();
    instru_ready = 1; auto_ack = 1;
    seen_pc.delete(); seen_data.delete();
    step();
    check("first_req", {63'd0, imem_req}, 64'd1);
    check("first_addr", imem_addr, 64'd0);
    step();
    check("no_b2b_req", {63'd0, imem_req}, 64'd0);
    check("lat_valid", {63'd0, instru_valid}, 64'd1);
    check("lat_instru", {32'd0, instru}, {32'd0, word(64'd0)});
    repeat (14) step();
    check("stream_cnt", {63'd0, seen_pc.size() >= 4}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (seen_pc.size() > i) begin
        check($sformatf("stream_pc%0d", i), seen_pc[i], 64'(4 * i));
        check($sformatf("stream_d%0d", i), {32'd0, seen_data[i]}, {32'd0, word(64'(4 * i))});
      end
    end

    // Fill to full with consumer stalled, then one pop restarts fetching
    do_reset();
    auto_ack = 1;
    repeat (8) step();
    check("full_valid", {63'd0, instru_valid}, 64'd1);
    check("full_head", instru_pc, 64'd0);
    repeat (4) step();
    check("full_noreq", {63'd0, imem_req}, 64'd0);
    instru_ready = 1;
    step();
    instru_ready = 0;
    check("pop_head", instru_pc, 64'd4);
    check("pop_noreq", {63'd0, imem_req}, 64'd0);
    step();
    check("resume_req", {63'd0, imem_req}, 64'd1);
    check("resume_addr", imem_addr, 64'd16);

    // Redirect with three entries queued
    do_reset();
    auto_ack = 1;
    repeat (6) step();
    check("br3_valid", {63'd0, instru_valid}, 64'd1);
    Brtaken = 1; branch_target = 64'h103;
    step();
    Brtaken = 0;
    check("br3_flush", {63'd0, instru_valid}, 64'd0);
    check("br3_noreq", {63'd0, imem_req}, 64'd0);
    step();
    check("br3_req", {63'd0, imem_req}, 64'd1);
    check("br3_addr", imem_addr, 64'h100);

    // Redirect while a request is outstanding; late response is dropped
    do_reset();
    auto_ack = 1;
    repeat (4) step();
    auto_ack = 0; imem_ack = 0;
    step();
    check("drop_req8", imem_addr, 64'h8);
    Brtaken = 1; branch_target = 64'h40;
    step();
    Brtaken = 0;
    check("drop_flush", {63'd0, instru_valid}, 64'd0);
    check("drop_hold", {63'd0, imem_req}, 64'd1);
    repeat (2) step();
    check("drop_addr", imem_addr, 64'h8);
    imem_ack = 1; imem_data = word(64'h8);
    step();
    imem_ack = 0;
    check("drop_done", {63'd0, imem_req}, 64'd0);
    check("drop_nodel", {63'd0, instru_valid}, 64'd0);
    step();
    check("drop_next", imem_addr, 64'h40);
    check("drop_nreq", {63'd0, imem_req}, 64'd1);

    // Redirect coincident with ack
    imem_ack = 1; imem_data = word(64'h40);
    Brtaken = 1; branch_target = 64'h80;
    step();
    imem_ack = 0; Brtaken = 0;
    check("coin_valid", {63'd0, instru_valid}, 64'd0);
    check("coin_noreq", {63'd0, imem_req}, 64'd0);
    step();
    check("coin_addr", imem_addr, 64'h80);

    // Simultaneous push and pop at count 2, then reset mid-request
    do_reset();
    auto_ack = 1;
    repeat (5) step();
    instru_ready = 1;
    step();
    auto_ack = 0; imem_ack = 0;
    check("pp_head", instru_pc, 64'd4);
    step();
    check("pp_head2", instru_pc, 64'd8);
    check("pp_valid2", {63'd0, instru_valid}, 64'd1);
    step();
    instru_ready = 0;
    check("pp_empty", {63'd0, instru_valid}, 64'd0);
    check("pp_req", imem_addr, 64'd12);
    #2;
    reset = 0;
    #1;
    check("mid_rst_req", {63'd0, imem_req}, 64'd0);
    check("mid_rst_addr", imem_addr, 64'd0);
    check("mid_rst_val", {63'd0, instru_valid}, 64'd0);
    imem_ack = 1; imem_data = word(64'd12);
    @(posedge clk);
    #1;
    reset = 1;
    step();
    imem_ack = 0;
    check("late_valid", {63'd0, instru_valid}, 64'd0);
    check("late_addr", imem_addr, 64'd0);
    check("late_req", {63'd0, imem_req}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard bound in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
